// File: rtl/wb_io_fifo_port.sv
// Wishbone classic I/O-space slave: CPU OUT writes push bytes into a FIFO
// that drains through a valid/ready byte stream; status/count/control
// registers share the same two-word window.
module wb_io_fifo_port #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned WAIT  = 1,
    parameter logic [14:0] BASE  = 15'h5b
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [19:1] wb_adr_i,
    input  logic        wb_we_i,
    input  logic        wb_tga_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [7:0]  out_dat,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [2:0]    wcnt, wcnt_nxt;

    logic          acc_we, acc_hi;
    logic [1:0]    acc_sel;
    logic [7:0]    acc_dat;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          enable, enable_nxt;
    logic          full, empty;

    logic [14:0]   wadr;
    logic          hit_lo, hit_hi, sel_hit;
    logic          a_we, a_hi;
    logic [1:0]    a_sel;
    logic          blocked;
    logic          do_ack, do_push, do_pop, do_flush, do_en;
    logic [7:0]    rd_lo, rd_hi;
    logic [15:0]   rdata;
    logic [7:0]    head_nxt;
    logic          unused_ok;

    // Address decode; only the two-word window in I/O space is ever selected
    assign wadr    = wb_adr_i[15:1];
    assign hit_lo  = (wadr == BASE);
    assign hit_hi  = (wadr == BASE + 15'd1);
    assign sel_hit = wb_cyc_i & wb_stb_i & wb_tga_i & (hit_lo | hit_hi);

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign unused_ok = ^{wb_adr_i[19:16], wb_dat_i[15:8]};

    // Access attributes: live bus in IDLE, latched copy once the cycle is owned
    always_comb begin
        a_we  = acc_we;
        a_hi  = acc_hi;
        a_sel = acc_sel;
        if (state == S_IDLE) begin
            a_we  = wb_we_i;
            a_hi  = hit_hi;
            a_sel = wb_sel_i;
        end
        blocked = a_we & ~a_hi & a_sel[0] & full;
    end

    // Next-state logic: wait-state countdown, FIFO-full back-pressure, abort
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                if (sel_hit) begin
                    wcnt_nxt  = 3'(WAIT);
                    state_nxt = ((WAIT != 0) || blocked) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!(wb_cyc_i && wb_stb_i)) begin
                    state_nxt = S_IDLE;
                end else if (wcnt != 3'd0) begin
                    wcnt_nxt = wcnt - 3'd1;
                end else if (!blocked) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            wcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Side effects fire only in the single ACK cycle; flush beats push/pop
    always_comb begin
        do_ack     = (state == S_ACK);
        do_push    = do_ack & acc_we & ~acc_hi & acc_sel[0] & ~full;
        do_en      = do_ack & acc_we &  acc_hi & acc_sel[0];
        do_flush   = do_en & acc_dat[0];
        do_pop     = out_valid & out_ready;

        rd_nxt     = rd_ptr;
        wr_nxt     = wr_ptr;
        count_nxt  = count;
        enable_nxt = enable;
        if (do_en) begin
            enable_nxt = acc_dat[1];
        end
        if (do_flush) begin
            rd_nxt    = '0;
            wr_nxt    = '0;
            count_nxt = '0;
        end else begin
            if (do_push) begin
                wr_nxt = wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_nxt = rd_ptr + AW'(1);
            end
            count_nxt = count + CW'(do_push) - CW'(do_pop);
        end
        head_nxt = (do_push && (wr_ptr == rd_nxt)) ? acc_dat : mem[rd_nxt];
    end

    // Read-data mux, each lane gated by its byte select
    always_comb begin
        rd_lo = a_hi ? {6'b0, enable, 1'b0} : 8'h00;
        rd_hi = a_hi ? 8'(count) : {5'b0, out_valid, full, empty};
        rdata = {(a_sel[1] ? rd_hi : 8'h00), (a_sel[0] ? rd_lo : 8'h00)};
    end

    // Bus outputs, latched access, FIFO pointers and registered stream head
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 16'h0000;
            acc_we    <= 1'b0;
            acc_hi    <= 1'b0;
            acc_sel   <= 2'b00;
            acc_dat   <= 8'h00;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            enable    <= 1'b0;
            out_valid <= 1'b0;
            out_dat   <= 8'h00;
        end else begin
            wb_ack_o <= (state_nxt == S_ACK);
            wb_dat_o <= ((state_nxt == S_ACK) && !a_we) ? rdata : 16'h0000;
            if ((state == S_IDLE) && sel_hit) begin
                acc_we  <= wb_we_i;
                acc_hi  <= hit_hi;
                acc_sel <= wb_sel_i;
                acc_dat <= wb_dat_i[7:0];
            end
            rd_ptr    <= rd_nxt;
            wr_ptr    <= wr_nxt;
            count     <= count_nxt;
            enable    <= enable_nxt;
            out_valid <= enable_nxt & (count_nxt != '0);
            out_dat   <= head_nxt;
        end
    end

    // FIFO storage
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= acc_dat;
        end
    end

endmodule
